// File: rtl/cpu_trace_buffer.sv
// Retirement trace buffer: captures CPU retire records into a FIFO and streams each as 4 x 32-bit beats.
// Optional PC window filter enabled by defining TRACE_PC_FILTER_EN (adds filt_lo / filt_hi inputs).
module cpu_trace_buffer #(
    parameter int DEPTH = 16,
    parameter int CNT_W = 16
) (
    input  logic                     clk,
    input  logic                     Reset,
    input  logic                     cap_en,
    input  logic                     PCWre,
    input  logic [31:0]              _PCOut,
    input  logic [31:0]              _instruction,
    input  logic                     RegWre,
    input  logic [4:0]               _ThirdReg,
    input  logic [31:0]              _WriteData,
`ifdef TRACE_PC_FILTER_EN
    input  logic [31:0]              filt_lo,
    input  logic [31:0]              filt_hi,
`endif
    output logic                     t_valid,
    input  logic                     t_ready,
    output logic [31:0]              t_data,
    output logic                     t_last,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full,
    output logic [CNT_W-1:0]         drop_cnt
);

    localparam int AW    = $clog2(DEPTH);
    localparam int REC_W = 102;

    localparam logic [AW-1:0]    PTR_ONE   = {{(AW-1){1'b0}}, 1'b1};
    localparam logic [AW-1:0]    PTR_ZERO  = {AW{1'b0}};
    localparam logic [AW:0]      CNT_ZERO  = {(AW+1){1'b0}};
    localparam logic [AW:0]      CNT_ONE   = {{AW{1'b0}}, 1'b1};
    localparam logic [AW:0]      CNT_FULL  = (AW+1)'(DEPTH);
    localparam logic [CNT_W-1:0] DROP_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] DROP_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] DROP_ZERO = {CNT_W{1'b0}};

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_B0   = 3'd1,
        ST_B1   = 3'd2,
        ST_B2   = 3'd3,
        ST_B3   = 3'd4
    } state_t;

    // Record layout: {pc[101:70], instr[69:38], regwre[37], reg[36:32], wdata[31:0]}
    logic [REC_W-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [AW-1:0]    rd_ptr_inc_s;
    state_t           state_r;
    logic             filt_ok_s;
    logic             push_req_s;
    logic             push_s;
    logic             pop_s;
    logic             drop_s;
    logic [AW:0]      count_nxt_s;
    logic [REC_W-1:0] rec_cur_s;
    logic [REC_W-1:0] rec_nxt_s;

    // PC window qualification of retirements
    always_comb begin
`ifdef TRACE_PC_FILTER_EN
        filt_ok_s = (_PCOut >= filt_lo) && (_PCOut <= filt_hi);
`else
        filt_ok_s = 1'b1;
`endif
    end

    // Push/pop/drop decisions; a full FIFO still accepts when the head record leaves this cycle
    always_comb begin
        rd_ptr_inc_s = rd_ptr_r + PTR_ONE;
        pop_s        = (state_r == ST_B3) && t_valid && t_ready;
        push_req_s   = cap_en && PCWre && filt_ok_s;
        push_s       = push_req_s && (!full || pop_s);
        drop_s       = push_req_s && full && !pop_s;
        rec_cur_s    = mem_r[rd_ptr_r];
        rec_nxt_s    = mem_r[rd_ptr_inc_s];
    end

    // Occupancy after this cycle's push and pop
    always_comb begin
        case ({push_s, pop_s})
            2'b10:   count_nxt_s = count + CNT_ONE;
            2'b01:   count_nxt_s = count - CNT_ONE;
            default: count_nxt_s = count;
        endcase
    end

    // Record storage; contents deliberately not reset
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= {_PCOut, _instruction, RegWre, _ThirdReg, _WriteData};
        end
    end

    // Pointers, occupancy flags and saturating drop counter
    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            wr_ptr_r <= PTR_ZERO;
            rd_ptr_r <= PTR_ZERO;
            count    <= CNT_ZERO;
            empty    <= 1'b1;
            full     <= 1'b0;
            drop_cnt <= DROP_ZERO;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_inc_s;
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            count <= count_nxt_s;
            empty <= (count_nxt_s == CNT_ZERO);
            full  <= (count_nxt_s == CNT_FULL);
            if (drop_s && (drop_cnt != DROP_MAX)) begin
                drop_cnt <= drop_cnt + DROP_ONE;
            end else begin
                drop_cnt <= drop_cnt;
            end
        end
    end

    // Read FSM with registered beat outputs; every state holds its beat until accepted.
    // After B3 only records stored before this cycle chain on, so a record pushed in the
    // same cycle as the last pop is read via IDLE once its write has landed.
    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            state_r <= ST_IDLE;
            t_valid <= 1'b0;
            t_data  <= 32'h0000_0000;
            t_last  <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (count != CNT_ZERO) begin
                        state_r <= ST_B0;
                        t_valid <= 1'b1;
                        t_data  <= rec_cur_s[101:70];
                        t_last  <= 1'b0;
                    end else begin
                        state_r <= ST_IDLE;
                        t_valid <= 1'b0;
                        t_data  <= 32'h0000_0000;
                        t_last  <= 1'b0;
                    end
                end
                ST_B0: begin
                    if (t_ready) begin
                        state_r <= ST_B1;
                        t_data  <= rec_cur_s[69:38];
                    end else begin
                        state_r <= ST_B0;
                    end
                end
                ST_B1: begin
                    if (t_ready) begin
                        state_r <= ST_B2;
                        t_data  <= {rec_cur_s[37], 26'd0, rec_cur_s[36:32]};
                    end else begin
                        state_r <= ST_B1;
                    end
                end
                ST_B2: begin
                    if (t_ready) begin
                        state_r <= ST_B3;
                        t_data  <= rec_cur_s[31:0];
                        t_last  <= 1'b1;
                    end else begin
                        state_r <= ST_B2;
                    end
                end
                ST_B3: begin
                    if (t_ready && (count != CNT_ONE)) begin
                        state_r <= ST_B0;
                        t_data  <= rec_nxt_s[101:70];
                        t_last  <= 1'b0;
                    end else if (t_ready) begin
                        state_r <= ST_IDLE;
                        t_valid <= 1'b0;
                        t_data  <= 32'h0000_0000;
                        t_last  <= 1'b0;
                    end else begin
                        state_r <= ST_B3;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    t_valid <= 1'b0;
                    t_data  <= 32'h0000_0000;
                    t_last  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_trace_buffer.sv
// Scoreboard bench for cpu_trace_buffer: expected beats are queued at stimulus time and
// popped by an independent monitor on every accepted beat.
module tb_cpu_trace_buffer;

    localparam int DEPTH = 16;
    localparam int CNT_W = 16;

    logic                   clk = 1'b0;
    logic                   Reset;
    logic                   cap_en;
    logic                   PCWre;
    logic [31:0]            pc_s;
    logic [31:0]            instr_s;
    logic                   regwre_s;
    logic [4:0]             reg_s;
    logic [31:0]            wdata_s;
    logic                   t_valid;
    logic                   t_ready;
    logic [31:0]            t_data;
    logic                   t_last;
    logic [$clog2(DEPTH):0] count;
    logic                   empty;
    logic                   full;
    logic [CNT_W-1:0]       drop_cnt;
`ifdef TRACE_PC_FILTER_EN
    logic [31:0]            filt_lo;
    logic [31:0]            filt_hi;
`endif

    int checks = 0;
    int errors = 0;
    logic [32:0] exp_q [$];

    always #5 clk = ~clk;

    cpu_trace_buffer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .Reset        (Reset),
        .cap_en       (cap_en),
        .PCWre        (PCWre),
        ._PCOut       (pc_s),
        ._instruction (instr_s),
        .RegWre       (regwre_s),
        ._ThirdReg    (reg_s),
        ._WriteData   (wdata_s),
`ifdef TRACE_PC_FILTER_EN
        .filt_lo      (filt_lo),
        .filt_hi      (filt_hi),
`endif
        .t_valid      (t_valid),
        .t_ready      (t_ready),
        .t_data       (t_data),
        .t_last       (t_last),
        .count        (count),
        .empty        (empty),
        .full         (full),
        .drop_cnt     (drop_cnt)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
        end
    endtask

    task automatic exp_rec(input logic [31:0] pc, input logic [31:0] instr, input logic rw,
                           input logic [4:0] rg, input logic [31:0] wd);
        exp_q.push_back({1'b0, pc});
        exp_q.push_back({1'b0, instr});
        exp_q.push_back({1'b0, rw, 26'd0, rg});
        exp_q.push_back({1'b1, wd});
    endtask

    // One retire cycle; called at posedge+1, returns at next posedge+1
    task automatic retire(input logic [31:0] pc, input logic [31:0] instr, input logic rw,
                          input logic [4:0] rg, input logic [31:0] wd, input bit expect_rec);
        pc_s = pc; instr_s = instr; regwre_s = rw; reg_s = rg; wdata_s = wd;
        PCWre = 1'b1;
        if (expect_rec) exp_rec(pc, instr, rw, rg, wd);
        @(posedge clk); #1;
        PCWre = 1'b0;
    endtask

    task automatic cycles(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while (!(empty && !t_valid) && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        check({name, "_drain_timeout"}, 32'(n < 300), 32'd1);
        check({name, "_beats_left"}, 32'(exp_q.size()), 32'd0);
    endtask

    // Monitor: each negedge with valid&ready is one handshake at the following posedge
    always @(negedge clk) begin
        logic [32:0] exp_beat;
        if (Reset && t_valid && t_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL beat_unexpected actual=%0b_%08h expected=none", t_last, t_data);
            end else begin
                exp_beat = exp_q.pop_front();
                if ({t_last, t_data} !== exp_beat) begin
                    errors++;
                    $display("FAIL beat actual=last%0b_0x%08h expected=last%0b_0x%08h",
                             t_last, t_data, exp_beat[32], exp_beat[31:0]);
                end
            end
        end
    end

    initial begin
        Reset = 1'b0; cap_en = 1'b0; PCWre = 1'b0; t_ready = 1'b0;
        pc_s = 32'd0; instr_s = 32'd0; regwre_s = 1'b0; reg_s = 5'd0; wdata_s = 32'd0;
`ifdef TRACE_PC_FILTER_EN
        filt_lo = 32'h0000_0000; filt_hi = 32'hFFFF_FFFF;
`endif
        cycles(3);
        Reset = 1'b1;
        cycles(2);
        // Reset state
        check("rst_t_valid", 32'(t_valid), 32'd0);
        check("rst_t_data", t_data, 32'd0);
        check("rst_t_last", 32'(t_last), 32'd0);
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_full", 32'(full), 32'd0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_drop", 32'(drop_cnt), 32'd0);

        // Retirements with capture disabled are ignored
        retire(32'h44, 32'h1, 1'b0, 5'd1, 32'h1, 1'b0);
        retire(32'h48, 32'h2, 1'b0, 5'd2, 32'h2, 1'b0);
        cycles(2);
        check("capoff_empty", 32'(empty), 32'd1);
        check("capoff_valid", 32'(t_valid), 32'd0);

        // Single record, host always ready; t_valid one cycle after push
        cap_en = 1'b1;
        t_ready = 1'b1;
        retire(32'h0, 32'h0232_4020, 1'b1, 5'd8, 32'h5, 1'b1);
        check("single_count", 32'(count), 32'd1);
        check("single_valid_lag", 32'(t_valid), 32'd0);
        @(posedge clk); #1;
        check("single_valid", 32'(t_valid), 32'd1);
        check("single_b0", t_data, 32'h0);
        wait_drain("single");
        check("single_empty", 32'(empty), 32'd1);

        // Stall for 10 cycles inside B1
        t_ready = 1'b0;
        retire(32'h40, 32'h0232_4020, 1'b0, 5'd31, 32'hDEAD_BEEF, 1'b1);
        cycles(1);
        check("stall_valid", 32'(t_valid), 32'd1);
        t_ready = 1'b1;
        cycles(1);
        t_ready = 1'b0;
        for (int k = 0; k < 10; k++) begin
            check("stall_data", t_data, 32'h0232_4020);
            check("stall_valid_hold", 32'(t_valid), 32'd1);
            check("stall_last", 32'(t_last), 32'd0);
            cycles(1);
        end
        t_ready = 1'b1;
        wait_drain("stall");

        // Overflow: 20 pushes, host stalled
        t_ready = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            retire(32'h1000 + 32'(i) * 32'd4, 32'hA000_0000 | 32'(i), i[0], i[4:0],
                   32'h5000 + 32'(i), i <= 16);
        end
        check("ovf_full", 32'(full), 32'd1);
        check("ovf_count", 32'(count), 32'd16);
        check("ovf_drop", 32'(drop_cnt), 32'd4);
        check("ovf_empty", 32'(empty), 32'd0);

        // Full FIFO: push lands in the same cycle as the B3 handshake
        t_ready = 1'b1;
        cycles(3);
        pc_s = 32'h2000; instr_s = 32'h0BAD_F00D; regwre_s = 1'b1; reg_s = 5'd17; wdata_s = 32'h7777;
        PCWre = 1'b1;
        exp_rec(32'h2000, 32'h0BAD_F00D, 1'b1, 5'd17, 32'h7777);
        check("b3push_last", 32'(t_last), 32'd1);
        cycles(1);
        PCWre = 1'b0;
        t_ready = 1'b0;
        check("b3push_drop", 32'(drop_cnt), 32'd4);
        check("b3push_count", 32'(count), 32'd16);
        check("b3push_full", 32'(full), 32'd1);
        t_ready = 1'b1;
        wait_drain("ovf");

        // Reset mid-transfer drops the partial record and t_valid immediately
        t_ready = 1'b0;
        retire(32'h300, 32'h3, 1'b0, 5'd3, 32'h3, 1'b0);
        cycles(1);
        check("mid_valid_pre", 32'(t_valid), 32'd1);
        Reset = 1'b0;
        #1;
        check("mid_valid_async", 32'(t_valid), 32'd0);
        check("mid_count", 32'(count), 32'd0);
        check("mid_empty", 32'(empty), 32'd1);
        cycles(1);
        Reset = 1'b1;
        t_ready = 1'b1;
        retire(32'h304, 32'h4, 1'b1, 5'd4, 32'h4, 1'b1);
        wait_drain("post_reset");

`ifdef TRACE_PC_FILTER_EN
        // PC window 0x8..0x10 inclusive
        filt_lo = 32'h8; filt_hi = 32'h10;
        for (int i = 0; i < 8; i++) begin
            retire(32'(i) * 32'd4, 32'h100 + 32'(i), 1'b1, 5'd2, 32'(i),
                   (i >= 2) && (i <= 4));
        end
        wait_drain("filter");
        check("filter_drop", 32'(drop_cnt), 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
